// File: rtl/vape_exec_sequencer.sv
// Central exec/kill/recover controller for the VAPE protection monitors.
// Aggregates monitor exec flags, latches causes and counts violations.
module vape_exec_sequencer #(
    parameter int          N_MON         = 4,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          HOLD_CYCLES   = 4,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pc,
    input  logic [N_MON-1:0] mon_exec,
    input  logic [N_MON-1:0] mon_en,
    input  logic             clr_cause,
    output logic             exec,
    output logic             reset_req,
    output logic [N_MON-1:0] cause,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [1:0]       state_o
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        KILL    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t           state;
    logic [HW-1:0]    hold;
    logic [N_MON-1:0] bad;
    logic             viol;
    logic             at_handler;
    logic [CNT_W-1:0] cnt_next;

    assign bad        = ~mon_exec & mon_en;
    assign viol       = |bad;
    assign at_handler = (pc == RESET_HANDLER);
    assign cnt_next   = (viol_cnt == CNT_MAX) ? viol_cnt : viol_cnt + CNT_W'(1);
    assign state_o    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            exec      <= 1'b0;
            reset_req <= 1'b0;
            cause     <= '0;
            viol_cnt  <= '0;
            hold      <= '0;
        end else begin
            unique case (state)
                BOOT: begin
                    if (at_handler && !viol) begin
                        state <= RUN;
                        exec  <= 1'b1;
                    end
                end
                RUN: begin
                    if (viol) begin
                        state     <= KILL;
                        exec      <= 1'b0;
                        reset_req <= 1'b1;
                        hold      <= HOLD_INIT;
                        // a same-edge clear keeps only the fresh violation bits
                        cause     <= clr_cause ? bad : (cause | bad);
                        viol_cnt  <= cnt_next;
                    end else if (clr_cause) begin
                        cause <= '0;
                    end
                end
                KILL: begin
                    cause <= cause | bad;
                    if (hold == '0) begin
                        state     <= RECOVER;
                        reset_req <= 1'b0;
                    end else begin
                        hold <= hold - HW'(1);
                    end
                end
                RECOVER: begin
                    if (viol) begin
                        state     <= KILL;
                        reset_req <= 1'b1;
                        hold      <= HOLD_INIT;
                        cause     <= cause | bad;
                        viol_cnt  <= cnt_next;
                    end else if (at_handler) begin
                        state <= RUN;
                        exec  <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vape_exec_sequencer.sv
// Randomized bench for vape_exec_sequencer against a cycle-level model.
// Directed scenarios cover kill hold, recovery, masking, clear and saturation.
module tb_vape_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [3:0]  mon_exec;
    logic [3:0]  mon_en;
    logic        clr_cause;
    logic        exec;
    logic        reset_req;
    logic [3:0]  cause;
    logic [7:0]  viol_cnt;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;

    // reference model: mode 0 boot, 1 run, 2 kill, 3 recover
    int         m_state;
    int         m_left;
    logic [3:0] m_cause;
    int         m_cnt;

    vape_exec_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .mon_exec  (mon_exec),
        .mon_en    (mon_en),
        .clr_cause (clr_cause),
        .exec      (exec),
        .reset_req (reset_req),
        .cause     (cause),
        .viol_cnt  (viol_cnt),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_cause = 4'h0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [15:0] p, input logic [3:0] me,
                              input logic [3:0] en, input logic clr);
        logic [3:0] b;
        logic       v;
        b = ~me & en;
        v = (b != 4'h0);
        case (m_state)
            0: if (p == 16'h0000 && !v) m_state = 1;
            1: begin
                if (v) begin
                    m_state = 2;
                    m_left  = 4;
                    m_cause = clr ? b : (m_cause | b);
                    if (m_cnt < 255) m_cnt++;
                end else if (clr) begin
                    m_cause = 4'h0;
                end
            end
            2: begin
                m_cause = m_cause | b;
                m_left--;
                if (m_left == 0) m_state = 3;
            end
            default: begin
                if (v) begin
                    m_state = 2;
                    m_left  = 4;
                    m_cause = m_cause | b;
                    if (m_cnt < 255) m_cnt++;
                end else if (p == 16'h0000) begin
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state", 32'(state_o), 32'(m_state));
        check("exec", 32'(exec), 32'(m_state == 1));
        check("reset_req", 32'(reset_req), 32'(m_state == 2));
        check("cause", 32'(cause), 32'(m_cause));
        check("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
    endtask

    task automatic step(input logic [15:0] p, input logic [3:0] me,
                        input logic [3:0] en, input logic clr);
        pc        = p;
        mon_exec  = me;
        mon_en    = en;
        clr_cause = clr;
        @(posedge clk);
        model_edge(p, me, en, clr);
        #1;
        compare_all();
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        pc        = 16'h0000;
        mon_exec  = 4'hF;
        mon_en    = 4'hF;
        clr_cause = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // reset release at handler with clean monitors
        step(16'h0000, 4'hF, 4'hF, 1'b0);
        check("t1_state", 32'(state_o), 32'd1);
        check("t1_exec", 32'(exec), 32'd1);

        // single violation: 4-cycle kill then recover
        step(16'h0040, 4'b1101, 4'hF, 1'b0);
        check("t2_cause", 32'(cause), 32'h2);
        check("t2_cnt", 32'(viol_cnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(16'h0044, 4'hF, 4'hF, 1'b0);
            check("t2_hold", 32'(reset_req), 32'd1);
        end
        step(16'h0048, 4'hF, 4'hF, 1'b0);
        check("t2_recover", 32'(state_o), 32'd3);

        // violation at handler in recover wins, then clean recovery
        step(16'h0000, 4'b1110, 4'hF, 1'b0);
        check("t3_kill", 32'(state_o), 32'd2);
        check("t3_cnt", 32'(viol_cnt), 32'd2);
        for (int i = 0; i < 4; i++) step(16'h0100, 4'hF, 4'hF, 1'b0);
        step(16'h0000, 4'hF, 4'hF, 1'b0);
        check("t3_run", 32'(state_o), 32'd1);
        check("t3_cause", 32'(cause), 32'h3);

        // masked monitor ignored
        step(16'h0010, 4'b1110, 4'b1110, 1'b0);
        check("t4_exec", 32'(exec), 32'd1);
        check("t4_cause", 32'(cause), 32'h3);

        // clear with violation, then plain clear
        step(16'h0020, 4'b0111, 4'hF, 1'b1);
        check("t5_cause", 32'(cause), 32'h8);
        check("t5_kill", 32'(state_o), 32'd2);
        for (int i = 0; i < 4; i++) step(16'h0200, 4'hF, 4'hF, 1'b1);
        step(16'h0000, 4'hF, 4'hF, 1'b0);
        step(16'h0030, 4'hF, 4'hF, 1'b1);
        check("t5_clear", 32'(cause), 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] p;
            logic [3:0]  me;
            logic [3:0]  en;
            p  = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            me = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            step(p, me, en, ($urandom_range(0, 9) == 0));
        end

        // drive counter to saturation with persistent violation
        guard = 0;
        while (m_cnt < 255 && guard < 4000) begin
            step(16'h0000, 4'b1110, 4'hF, 1'b0);
            guard++;
        end
        check("t6_reach", 32'(m_cnt), 32'd255);
        for (int i = 0; i < 12; i++) step(16'h0000, 4'b1110, 4'hF, 1'b0);
        check("t6_sat", 32'(viol_cnt), 32'hFF);

        guard = 0;
        while (m_state != 3 && guard < 20) begin
            step(16'h0300, 4'hF, 4'hF, 1'b0);
            guard++;
        end
        check("t6_recover", 32'(state_o), 32'd3);
        step(16'h0300, 4'b1011, 4'hF, 1'b0);
        step(16'h0300, 4'hF, 4'hF, 1'b0);
        check("t6_kill2", 32'(reset_req), 32'd1);
        check("t6_cnt", 32'(viol_cnt), 32'hFF);

        // async reset mid-kill, away from any clock edge
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_rr_async", 32'(reset_req), 32'd0);
        check("t6_boot", 32'(state_o), 32'd0);
        check("t6_cnt_clr", 32'(viol_cnt), 32'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        step(16'h0000, 4'hF, 4'hF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
